// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns single-cycle set/clear requests into fixed-width,
// mutually exclusive s/r pulses for a cross-coupled SR latch. Each pulse is
// followed by a quiet gap. At the end of the gap the latch q is read back and
// compared with the value the operation should have produced.
module sr_latch_driver #(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   input  logic q,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict,
   output logic drop,
   output logic err,
   output logic known
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SET_P = 2'd1,
      CLR_P = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

   // Parameter sanity checks, evaluated at elaboration only
   if (PULSE_W < 1 || PULSE_W > 255) begin : g_bad_pulse_w
      $error("sr_latch_driver: PULSE_W=%0d outside 1..255", PULSE_W);
   end
   if (GAP_W < 1 || GAP_W > 255) begin : g_bad_gap_w
      $error("sr_latch_driver: GAP_W=%0d outside 1..255", GAP_W);
   end
   if (CNT_W < 1 || CNT_W > 30 || PULSE_W > (1 << CNT_W) || GAP_W > (1 << CNT_W)) begin : g_bad_cnt_w
      $error("sr_latch_driver: CNT_W=%0d too narrow for PULSE_W/GAP_W", CNT_W);
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exp_q, exp_d;
   logic             s_q, s_d;
   logic             r_q, r_d;
   logic             busy_q, busy_d;
   logic             conflict_q, conflict_d;
   logic             drop_q, drop_d;
   logic             err_q, err_d;
   logic             known_q, known_d;
   logic             any_req;

   assign any_req = set_req | clr_req;

   // Next-state, counter, status and registered-output computation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      conflict_d = 1'b0;
      drop_d     = 1'b0;
      err_d      = err_q;
      known_d    = known_q;

      case (state_q)
         IDLE: begin
            if (set_req && clr_req) begin
               conflict_d = 1'b1;
            end else if (set_req) begin
               state_d = SET_P;
               cnt_d   = PULSE_LOAD;
               exp_d   = 1'b1;
            end else if (clr_req) begin
               state_d = CLR_P;
               cnt_d   = PULSE_LOAD;
               exp_d   = 1'b0;
            end
         end
         SET_P, CLR_P: begin
            drop_d = any_req;
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            drop_d = any_req;
            if (cnt_q == '0) begin
               state_d = IDLE;
               known_d = 1'b1;
               if (q != exp_q) begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      s_d    = (state_d == SET_P);
      r_d    = (state_d == CLR_P);
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset that overrides any pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         exp_q      <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         known_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         s_q        <= s_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         known_q    <= known_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;
   assign drop     = drop_q;
   assign err      = err_q;
   assign known    = known_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed bench for sr_latch_driver with a behavioural
// SR latch on the s/r outputs feeding q back, plus a fault-injection override.
module tb_sr_latch_driver;

   logic clk = 1'b0;
   logic rst;
   logic set_req;
   logic clr_req;
   logic q_fb;
   logic s, r, busy, conflict, drop, err, known;

   logic latch_q;
   logic force_q0;

   int checks = 0;
   int errors = 0;

   sr_latch_driver #(.PULSE_W(4), .GAP_W(2), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .q        (q_fb),
      .s        (s),
      .r        (r),
      .busy     (busy),
      .conflict (conflict),
      .drop     (drop),
      .err      (err),
      .known    (known)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Behavioural cross-coupled latch: holds unless exactly one of s/r is high
   always @(s or r) begin
      if (s && !r)
         latch_q = 1'b1;
      else if (r && !s)
         latch_q = 1'b0;
   end

   assign q_fb = force_q0 ? 1'b0 : latch_q;

   task automatic check_output(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge, checking invariants every cycle
   task automatic cyc();
      @(posedge clk);
      #1;
      check_output("inv_s_and_r", s & r, 1'b0);
      check_output("inv_pulse_implies_busy", (s | r) & ~busy, 1'b0);
      check_output("inv_conflict_and_drop", conflict & drop, 1'b0);
   endtask

   task automatic apply_stimulus(input logic set_v, input logic clr_v);
      set_req = set_v;
      clr_req = clr_v;
   endtask

   initial begin
      latch_q  = 1'b0;
      force_q0 = 1'b0;
      rst      = 1'b1;
      apply_stimulus(1'b0, 1'b0);

      // Reset state
      cyc();
      cyc();
      check_output("rst_s", s, 1'b0);
      check_output("rst_r", r, 1'b0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_conflict", conflict, 1'b0);
      check_output("rst_drop", drop, 1'b0);
      check_output("rst_err", err, 1'b0);
      check_output("rst_known", known, 1'b0);
      rst = 1'b0;

      // Set operation: request at cycle 0
      apply_stimulus(1'b1, 1'b0);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) cyc();
         check_output("set_s_high", s, 1'b1);
         check_output("set_r_low", r, 1'b0);
         check_output("set_busy_pulse", busy, 1'b1);
      end
      for (int k = 5; k <= 6; k++) begin
         cyc();
         check_output("set_gap_s", s, 1'b0);
         check_output("set_gap_busy", busy, 1'b1);
         check_output("set_gap_known", known, 1'b0);
      end
      cyc();
      check_output("set_done_busy", busy, 1'b0);
      check_output("set_done_known", known, 1'b1);
      check_output("set_done_err", err, 1'b0);
      check_output("set_latch_q", latch_q, 1'b1);

      // Clear operation at the first idle cycle
      apply_stimulus(1'b0, 1'b1);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) cyc();
         check_output("clr_r_high", r, 1'b1);
         check_output("clr_s_low", s, 1'b0);
      end
      cyc();
      check_output("clr_gap_r", r, 1'b0);
      cyc();
      cyc();
      check_output("clr_done_busy", busy, 1'b0);
      check_output("clr_latch_q", latch_q, 1'b0);
      check_output("clr_latch_qbar", ~latch_q, 1'b1);
      check_output("clr_done_err", err, 1'b0);

      // Simultaneous requests while idle
      apply_stimulus(1'b1, 1'b1);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      check_output("conf_pulse", conflict, 1'b1);
      check_output("conf_s", s, 1'b0);
      check_output("conf_r", r, 1'b0);
      check_output("conf_busy", busy, 1'b0);
      cyc();
      check_output("conf_one_cycle", conflict, 1'b0);
      check_output("conf_busy_after", busy, 1'b0);
      check_output("conf_latch_q", latch_q, 1'b0);

      // Request while busy: set at cycle 0, clear at cycle 3
      apply_stimulus(1'b1, 1'b0);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      cyc();
      cyc();
      check_output("busy_no_drop_c3", drop, 1'b0);
      apply_stimulus(1'b0, 1'b1);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      check_output("busy_drop_c4", drop, 1'b1);
      check_output("busy_s_c4", s, 1'b1);
      check_output("busy_r_c4", r, 1'b0);
      cyc();
      check_output("busy_drop_c5", drop, 1'b0);
      check_output("busy_s_c5", s, 1'b0);
      check_output("busy_r_c5", r, 1'b0);
      cyc();
      check_output("busy_busy_c6", busy, 1'b1);
      cyc();
      check_output("busy_done_c7", busy, 1'b0);
      check_output("busy_latch_q", latch_q, 1'b1);
      check_output("busy_err", err, 1'b0);

      // Readback fault: q held at 0 during a set operation
      force_q0 = 1'b1;
      apply_stimulus(1'b1, 1'b0);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      for (int k = 2; k <= 6; k++) cyc();
      check_output("fault_err_c6", err, 1'b0);
      cyc();
      check_output("fault_err_c7", err, 1'b1);
      force_q0 = 1'b0;
      // A correct clear operation must leave err sticky
      apply_stimulus(1'b0, 1'b1);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      for (int k = 2; k <= 7; k++) cyc();
      check_output("fault_sticky_busy", busy, 1'b0);
      check_output("fault_sticky_q", latch_q, 1'b0);
      check_output("fault_err_sticky", err, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_output("fault_err_cleared", err, 1'b0);

      // Reset in the middle of a set pulse
      apply_stimulus(1'b1, 1'b0);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      cyc();
      check_output("midrst_s_before", s, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_output("midrst_s", s, 1'b0);
      check_output("midrst_busy", busy, 1'b0);
      check_output("midrst_known", known, 1'b0);
      apply_stimulus(1'b0, 1'b1);
      cyc();
      apply_stimulus(1'b0, 1'b0);
      check_output("midrst_clr_r", r, 1'b1);
      check_output("midrst_clr_busy", busy, 1'b1);
      for (int k = 2; k <= 7; k++) cyc();
      check_output("midrst_clr_done", busy, 1'b0);
      check_output("midrst_clr_known", known, 1'b1);
      check_output("midrst_clr_err", err, 1'b0);
      check_output("midrst_latch_q", latch_q, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
